// File: rtl/intc_lite.sv
// AXI4-Lite interrupt controller: captures rising edges of irq_in, masks them per source and
// globally, and drives one registered irq line; software reads a vector register and acks with W1C.
module intc_lite #(
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_IRQ            = 4
) (
    input  logic                          s_axi_aclk,
    input  logic                          reset,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic [1:0]                    s_axi_bresp,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    input  logic [NUM_IRQ-1:0]            irq_in,
    output logic                          irq
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_ISR = idx_t'(0);
    localparam idx_t IDX_IPR = idx_t'(1);
    localparam idx_t IDX_IER = idx_t'(2);
    localparam idx_t IDX_IAR = idx_t'(3);
    localparam idx_t IDX_MER = idx_t'(4);
    localparam idx_t IDX_IVR = idx_t'(5);

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} r_state_t;

    w_state_t                   w_state_q, w_state_d;
    r_state_t                   r_state_q, r_state_d;
    logic [NUM_IRQ-1:0]         isr_q, isr_d;
    logic [NUM_IRQ-1:0]         ier_q, ier_d;
    logic                       mer_q, mer_d;
    logic [NUM_IRQ-1:0]         irq_in_dly_q, irq_in_dly_d;
    logic                       irq_q, irq_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;

    logic [NUM_IRQ-1:0]         rise;
    logic [NUM_IRQ-1:0]         clr;
    logic [NUM_IRQ-1:0]         ipr;
    logic [31:0]                rd_word;
    idx_t                       aw_idx;
    idx_t                       ar_idx;

    function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    // Lowest-numbered pending source wins; all ones means nothing pending.
    function automatic logic [31:0] prio_enc(input logic [NUM_IRQ-1:0] v);
        logic [31:0] r;
        r = '1;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) r = 32'(i);
        end
        return r;
    endfunction

    assign aw_idx = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = araddr_q[C_S_AXI_ADDR_WIDTH-1:2];
    assign rise   = irq_in & ~irq_in_dly_q;
    assign ipr    = isr_q & ier_q;

    always_comb begin
        w_state_d = w_state_q;
        ier_d     = ier_q;
        mer_d     = mer_q;
        clr       = '0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) w_state_d = W_ACCEPT;
            end
            W_ACCEPT: begin
                w_state_d = W_RESP;
                case (aw_idx)
                    IDX_IER: ier_d = s_axi_wdata[NUM_IRQ-1:0];
                    IDX_IAR: clr   = s_axi_wdata[NUM_IRQ-1:0];
                    IDX_MER: mer_d = s_axi_wdata[0];
                    default: ;
                endcase
            end
            W_RESP: begin
                if (s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Set after clear so a rise coinciding with an ack is never lost.
    always_comb begin
        irq_in_dly_d = irq_in;
        isr_d        = (isr_q & ~clr) | rise;
        irq_d        = mer_q & (|ipr);
    end

    always_comb begin
        case (ar_idx)
            IDX_ISR: rd_word = zext(isr_q);
            IDX_IPR: rd_word = zext(ipr);
            IDX_IER: rd_word = zext(ier_q);
            IDX_MER: rd_word = {31'd0, mer_q};
            IDX_IVR: rd_word = prio_enc(ipr);
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    araddr_d  = s_axi_araddr;
                    r_state_d = R_ACCEPT;
                end
            end
            R_ACCEPT: begin
                rdata_d   = rd_word;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (s_axi_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            isr_q        <= '0;
            ier_q        <= '0;
            mer_q        <= 1'b0;
            irq_in_dly_q <= '0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            isr_q        <= isr_d;
            ier_q        <= ier_d;
            mer_q        <= mer_d;
            irq_in_dly_q <= irq_in_dly_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
        end
    end

    // Captured read address is only consumed after capture, so it needs no reset.
    always_ff @(posedge s_axi_aclk) begin
        araddr_q <= araddr_d;
    end

    assign s_axi_awready = (w_state_q == W_ACCEPT);
    assign s_axi_wready  = (w_state_q == W_ACCEPT);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = (r_state_q == R_ACCEPT);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign irq           = irq_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_wdata,
                         s_axi_awaddr[1:0], araddr_q[1:0]};

endmodule

// File: tb/tb_intc_lite.sv
// Self-checking bench for intc_lite: register reads go through an expected-value queue.
module tb_intc_lite;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, irq;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb, irq_in;
    logic [1:0]  bresp, rresp;

    intc_lite #(.C_S_AXI_ADDR_WIDTH(5), .NUM_IRQ(4)) dut (
        .s_axi_aclk(clk), .reset(reset),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .irq_in(irq_in), .irq(irq)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    sb_t         sb_q[$];
    rd_vec_t     rst_tab[8];
    int          errors = 0;
    int          checks = 0;
    logic        irq_at_commit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pulse bits are raised on irq_in so that they are first sampled on the commit edge.
    task automatic axi_write(input string name, input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] pulse);
        int   n;
        logic hs_seen;
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        n       = 0;
        hs_seen = 1'b0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                hs_seen = awready && wready;
                irq_in  = irq_in | pulse;
            end
        end while (!bvalid && n < 20);
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        irq_in        = irq_in & ~pulse;
        irq_at_commit = irq;
        check({name, " wlat"}, 32'(n), 32'd2);
        check({name, " awready"}, 32'(hs_seen), 32'd1);
        check({name, " bresp"}, 32'(bresp), 32'd0);
        if (bready) begin
            tick();
            check({name, " bdone"}, 32'(bvalid), 32'd0);
        end
    endtask

    task automatic axi_read(input string name, input logic [4:0] addr, input logic [31:0] exp);
        int   n;
        logic ar_seen;
        sb_t  e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        araddr  = addr;
        arvalid = 1'b1;
        n       = 0;
        ar_seen = 1'b0;
        do begin
            tick();
            n++;
            if (n == 1) ar_seen = arready;
        end while (!rvalid && n < 20);
        arvalid = 1'b0;
        e = sb_q.pop_front();
        check(e.name, rdata, e.exp);
        check({name, " rlat"}, 32'(n), 32'd2);
        check({name, " arready"}, 32'(ar_seen), 32'd1);
        check({name, " rresp"}, 32'(rresp), 32'd0);
        if (rready) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1; awaddr = '0; araddr = '0;
        awprot = '0; arprot = '0; wdata = '0; wstrb = 4'hF; irq_in = '0;

        rst_tab[0] = '{5'h00, 32'h0000_0000, "rst ISR"};
        rst_tab[1] = '{5'h04, 32'h0000_0000, "rst IPR"};
        rst_tab[2] = '{5'h08, 32'h0000_0000, "rst IER"};
        rst_tab[3] = '{5'h0C, 32'h0000_0000, "rst IAR"};
        rst_tab[4] = '{5'h10, 32'h0000_0000, "rst MER"};
        rst_tab[5] = '{5'h14, 32'hFFFF_FFFF, "rst IVR"};
        rst_tab[6] = '{5'h18, 32'h0000_0000, "rst 0x18"};
        rst_tab[7] = '{5'h1C, 32'h0000_0000, "rst 0x1C"};

        repeat (3) tick();
        check("rst outputs", 32'({awready, wready, bvalid, arready, rvalid, irq}), 32'd0);
        check("rst rdata", rdata, 32'd0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) axi_read(rst_tab[i].name, rst_tab[i].addr, rst_tab[i].exp);
        check("rst irq", 32'(irq), 32'd0);

        // Single source, enable, latency and acknowledge.
        axi_write("wr ISR", 5'h00, 32'hF, 4'h0);
        axi_read("ISR ro", 5'h00, 32'h0);
        axi_write("IER=1", 5'h08, 32'h1, 4'h0);
        axi_write("MER=1", 5'h10, 32'h1, 4'h0);
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
        check("irq after N", 32'(irq), 32'd0);
        tick();
        check("irq after N+1", 32'(irq), 32'd1);
        axi_read("ISR p0", 5'h00, 32'h1);
        axi_read("IVR p0", 5'h14, 32'h0);
        axi_read("IPR p0", 5'h04, 32'h1);
        axi_write("IAR=1", 5'h0C, 32'h1, 4'h0);
        check("irq at ack commit", 32'(irq_at_commit), 32'd1);
        check("irq after ack", 32'(irq), 32'd0);
        axi_read("ISR acked", 5'h00, 32'h0);
        axi_read("IVR none", 5'h14, 32'hFFFF_FFFF);

        // Two sources with partial enable, priority and master mask.
        axi_write("IER=4", 5'h08, 32'h4, 4'h0);
        irq_in = 4'b0110;
        tick();
        irq_in = 4'b0000;
        tick();
        tick();
        check("irq src2", 32'(irq), 32'd1);
        axi_read("ISR 2+1", 5'h00, 32'h6);
        axi_read("IPR 2+1", 5'h04, 32'h4);
        axi_read("IVR 2", 5'h14, 32'h2);
        axi_write("IER=6", 5'h08, 32'h6, 4'h0);
        axi_read("IVR 1", 5'h14, 32'h1);
        axi_write("MER=0", 5'h10, 32'h0, 4'h0);
        check("irq at MER commit", 32'(irq_at_commit), 32'd1);
        check("irq masked", 32'(irq), 32'd0);
        axi_read("ISR kept", 5'h00, 32'h6);
        axi_read("IPR masked MER", 5'h04, 32'h6);
        axi_read("MER 0", 5'h10, 32'h0);
        axi_write("IAR=6", 5'h0C, 32'h6, 4'h0);
        axi_write("MER=1b", 5'h10, 32'h1, 4'h0);

        // Acknowledge on the same edge as a new rise: the rise survives.
        axi_write("IAR race", 5'h0C, 32'h1, 4'b0001);
        axi_read("ISR race", 5'h00, 32'h1);
        axi_write("IAR race clr", 5'h0C, 32'h1, 4'h0);
        axi_read("ISR race clr", 5'h00, 32'h0);

        // Held level gives one event only.
        axi_write("IER=8", 5'h08, 32'h8, 4'h0);
        irq_in = 4'b1000;
        tick();
        tick();
        check("irq level", 32'(irq), 32'd1);
        axi_read("ISR level", 5'h00, 32'h8);
        axi_write("IAR=8", 5'h0C, 32'h8, 4'h0);
        check("irq level acked", 32'(irq), 32'd0);
        axi_read("ISR held", 5'h00, 32'h0);
        repeat (4) tick();
        check("irq no retrig", 32'(irq), 32'd0);
        axi_read("ISR no retrig", 5'h00, 32'h0);
        irq_in = 4'b0000;
        tick();
        irq_in = 4'b1000;
        tick();
        tick();
        check("irq retrig", 32'(irq), 32'd1);
        axi_read("ISR retrig", 5'h00, 32'h8);
        irq_in = 4'b0000;
        axi_write("IAR=8b", 5'h0C, 32'h8, 4'h0);

        // Response stalls, upper-bit masking, unmapped offset, reset abort.
        bready = 1'b0;
        axi_write("IER all", 5'h08, 32'hFFFF_FFFF, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bvalid stall", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        tick();
        check("bvalid released", 32'(bvalid), 32'd0);
        rready = 1'b0;
        axi_read("IER masked", 5'h08, 32'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rvalid stall", 32'(rvalid), 32'd1);
            check("rdata stable", rdata, 32'hF);
        end
        rready = 1'b1;
        tick();
        check("rvalid released", 32'(rvalid), 32'd0);
        rready = 1'b0;
        axi_read("rd 0x1C", 5'h1C, 32'h0);
        reset  = 1'b1;
        irq_in = 4'b0001;
        tick();
        check("rvalid reset abort", 32'(rvalid), 32'd0);
        tick();
        check("irq in reset", 32'(irq), 32'd0);
        reset  = 1'b0;
        rready = 1'b1;
        tick();
        axi_read("ISR high at release", 5'h00, 32'h1);
        axi_read("IER after reset", 5'h08, 32'h0);
        check("irq after reset", 32'(irq), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
